// File: rtl/fb_swap_if.sv
// Bundles the raycast-transformer / video-timing handshake of the frame-buffer
// swap controller. The controller uses the slave modport; the block driving
// pixel strobes and frame timing uses the master modport.
interface fb_swap_if;
    logic        ray_valid_in;
    logic        ray_last_pixel_in;
    logic        frame_start_in;
    logic [1:0]  wr_en_out;
    logic        rd_buf_sel_out;
    logic [1:0]  fb_ready_to_switch_out;
    logic [15:0] frame_count_out;
    logic [15:0] repeat_count_out;
    logic        pixel_count_err_out;
    logic        overrun_err_out;

    modport slave (
        input  ray_valid_in,
        input  ray_last_pixel_in,
        input  frame_start_in,
        output wr_en_out,
        output rd_buf_sel_out,
        output fb_ready_to_switch_out,
        output frame_count_out,
        output repeat_count_out,
        output pixel_count_err_out,
        output overrun_err_out
    );

    modport master (
        output ray_valid_in,
        output ray_last_pixel_in,
        output frame_start_in,
        input  wr_en_out,
        input  rd_buf_sel_out,
        input  fb_ready_to_switch_out,
        input  frame_count_out,
        input  repeat_count_out,
        input  pixel_count_err_out,
        input  overrun_err_out
    );
endinterface

// File: rtl/fb_swap_controller.sv
// Double-buffered frame-buffer swap controller. The raycaster renders into the
// back buffer while the display scans the front buffer; buffers are exchanged
// only when a frame is complete and the display signals a new frame start.
// If rendering is late the display shows the old frame again, which is counted.
module fb_swap_controller #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int FRAME_PIXELS  = SCREEN_WIDTH * SCREEN_HEIGHT
) (
    input  logic       pixel_clk_in,
    input  logic       rst_in,
    fb_swap_if.slave   bus
);

    typedef enum logic [1:0] {
        RENDER       = 2'd0,
        WAIT_DISPLAY = 2'd1,
        SWAP         = 2'd2
    } state_t;

    localparam logic [16:0] FRAME_PIXELS_W = 17'(FRAME_PIXELS);

    state_t      state;
    state_t      state_next;
    logic        rd_buf_sel;
    logic        wr_buf_sel;
    logic [15:0] pix_count;
    logic [15:0] frame_count;
    logic [15:0] repeat_count;
    logic [1:0]  ready;
    logic        pixel_err;
    logic        overrun_err;
    logic        write_accept;
    logic        frame_len_bad;
    logic [1:0]  wr_en;

    // The back buffer is always the one the display is not reading.
    assign wr_buf_sel = ~rd_buf_sel;

    // A pixel is written only while rendering, and never during reset.
    assign write_accept = (state == RENDER) && bus.ray_valid_in && !rst_in;

    // Frame length check includes the pixel arriving alongside the last flag.
    assign frame_len_bad = ({1'b0, pix_count} + 17'(bus.ray_valid_in)) != FRAME_PIXELS_W;

    // Frame-sequencing state register.
    always_ff @(posedge pixel_clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst_in) begin
            state <= RENDER;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: finish frame, wait for display, swap for one cycle.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            RENDER: begin
                if (bus.ray_last_pixel_in && bus.frame_start_in) begin
                    state_next = SWAP;
                end else if (bus.ray_last_pixel_in) begin
                    state_next = WAIT_DISPLAY;
                end
            end
            WAIT_DISPLAY: begin
                if (bus.frame_start_in) begin
                    state_next = SWAP;
                end
            end
            SWAP:    state_next = RENDER;
            default: state_next = RENDER;
        endcase
    end

    // Zero-latency write enable steering the accepted pixel to the back buffer.
    always_comb begin
        wr_en = 2'b00;
        if (write_accept) begin
            wr_en = wr_buf_sel ? 2'b10 : 2'b01;
        end
    end

    // Buffer selection, counters, handshake and sticky error flags.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            rd_buf_sel   <= 1'b1;
            pix_count    <= '0;
            frame_count  <= '0;
            repeat_count <= '0;
            ready        <= 2'b00;
            pixel_err    <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            case (state)
                RENDER: begin
                    if (bus.ray_valid_in) begin
                        pix_count <= pix_count + 16'd1;
                        ready     <= 2'b00;
                    end
                    if (bus.ray_last_pixel_in && frame_len_bad) begin
                        pixel_err <= 1'b1;
                    end
                    // Display restarted before the frame finished: old frame shown again.
                    if (bus.frame_start_in && !bus.ray_last_pixel_in &&
                        repeat_count != 16'hFFFF) begin
                        repeat_count <= repeat_count + 16'd1;
                    end
                end
                WAIT_DISPLAY: begin
                    if (bus.ray_valid_in) begin
                        overrun_err <= 1'b1;
                    end
                end
                SWAP: begin
                    if (bus.ray_valid_in) begin
                        overrun_err <= 1'b1;
                    end
                    rd_buf_sel  <= ~rd_buf_sel;
                    frame_count <= frame_count + 16'd1;
                    pix_count   <= '0;
                    ready       <= 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign bus.wr_en_out              = wr_en;
    assign bus.rd_buf_sel_out         = rd_buf_sel;
    assign bus.fb_ready_to_switch_out = ready;
    assign bus.frame_count_out        = frame_count;
    assign bus.repeat_count_out       = repeat_count;
    assign bus.pixel_count_err_out    = pixel_err;
    assign bus.overrun_err_out        = overrun_err;

endmodule

// File: doc/fb_swap_controller.md
FB_SWAP_CONTROLLER -- requirements
Module: fb_swap_controller

Interface
REQ-001 Parameters: SCREEN_WIDTH, default 320, raycast frame width in pixels; SCREEN_HEIGHT, default 180, frame height; FRAME_PIXELS, default SCREEN_WIDTH*SCREEN_HEIGHT (57600).
REQ-002 pixel_clk_in  input  1  sole clock; all state updates on posedge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 ray_valid_in  input  1  transformer pixel-write strobe, one pixel per cycle high.
REQ-005 ray_last_pixel_in  input  1  one-cycle pulse coincident with the last pixel write of a frame.
REQ-006 frame_start_in  input  1  one-cycle pulse from video timing; display has finished reading the front buffer.
REQ-007 wr_en_out  output  2  per-buffer write enable; bit0 = buffer A, bit1 = buffer B.
REQ-008 rd_buf_sel_out  output  1  buffer the display reads; 0 = A, 1 = B.
REQ-009 fb_ready_to_switch_out  output  2  2'b11 = new back buffer free, transformer may accept next packet; else 2'b00.
REQ-010 frame_count_out  output  16  completed swaps, wraps 65535 -> 0.
REQ-011 repeat_count_out  output  16  display frames shown twice (render late), saturates at 65535.
REQ-012 pixel_count_err_out  output  1  sticky: a frame ended with write count != FRAME_PIXELS.
REQ-013 overrun_err_out  output  1  sticky: write attempted while no back buffer was writable.

Function
REQ-014 Internal wr_buf_sel is always ~rd_buf_sel_out; the two buffers are never both read and written.
REQ-015 States: RENDER (back buffer writable), WAIT_DISPLAY (frame complete, awaiting frame_start_in), SWAP (one cycle, exchange buffers).
REQ-016 wr_en_out is combinational, zero latency: in RENDER with ray_valid_in=1, wr_en_out = 2'b01 if wr_buf_sel=0 else 2'b10; otherwise 2'b00.
REQ-017 16-bit pix_count increments on each accepted write (RENDER and ray_valid_in); clears to 0 in SWAP.
REQ-018 RENDER, ray_last_pixel_in=1, frame_start_in=0 -> WAIT_DISPLAY next cycle.
REQ-019 RENDER, ray_last_pixel_in=1, frame_start_in=1 same cycle -> SWAP next cycle; repeat_count_out unchanged.
REQ-020 RENDER, frame_start_in=1, ray_last_pixel_in=0 -> stay RENDER; repeat_count_out +1 (saturating); no swap.
REQ-021 WAIT_DISPLAY, frame_start_in=1 -> SWAP next cycle; frame_start_in=0 -> remain.
REQ-022 SWAP: toggle rd_buf_sel_out, frame_count_out +1, pix_count <= 0, fb_ready_to_switch_out <= 2'b11, -> RENDER; all registered changes visible the cycle after SWAP.
REQ-023 fb_ready_to_switch_out clears to 2'b00 on the cycle after the first accepted write following SWAP; it is 2'b00 in every other condition.
REQ-024 On cycle with ray_last_pixel_in=1 in RENDER, if (pix_count + ray_valid_in) != FRAME_PIXELS, set pixel_count_err_out.
REQ-025 ray_valid_in=1 in WAIT_DISPLAY or SWAP: write dropped (wr_en_out=0), overrun_err_out set, pix_count unchanged.
REQ-026 ray_last_pixel_in in WAIT_DISPLAY or SWAP is ignored apart from REQ-025.
REQ-027 Sticky error flags clear only on rst_in.

Reset
REQ-028 rst_in=1 at posedge, any state including mid-frame: state <= RENDER, rd_buf_sel_out <= 1 (write A, display B), pix_count <= 0, fb_ready_to_switch_out <= 2'b00, frame_count_out <= 0, repeat_count_out <= 0, both error flags <= 0.
REQ-029 wr_en_out = 2'b00 in any cycle rst_in=1, regardless of ray_valid_in.
REQ-030 First frame after reset is written without a 2'b11 handshake (transformer starts ready).

Verification
REQ-031 Normal frame: 57600 writes, last with ray_last_pixel_in, frame_start_in 10 cycles later -> wr_en_out=2'b01 throughout, WAIT_DISPLAY for 10 cycles, SWAP, then rd_buf_sel_out=0, frame_count_out=1, fb_ready_to_switch_out=2'b11, no errors.
REQ-032 Simultaneous: ray_last_pixel_in and frame_start_in same cycle -> SWAP next cycle, repeat_count_out=0.
REQ-033 Late render: two frame_start_in pulses during RENDER -> repeat_count_out=2, rd_buf_sel_out unchanged at 1.
REQ-034 Short frame: ray_last_pixel_in on 57599th write -> pixel_count_err_out=1 and stays 1 through subsequent good frames.
REQ-035 Overrun: ray_valid_in=1 in WAIT_DISPLAY -> wr_en_out=2'b00, overrun_err_out=1.
REQ-036 Reset mid-frame after 1000 writes into B (frame_count_out=1) -> next cycle rd_buf_sel_out=1, frame_count_out=0, next write gives wr_en_out=2'b01.
